// File: rtl/frame_gate_ctrl.sv
// rtl/frame_gate_ctrl.sv - frame-granular gate for sensor video: passes or blocks whole frames
// and counts passed/dropped frames.
module frame_gate_ctrl #(
  parameter int SENSOR_DAT_WIDTH = 10,
  parameter int CHANNEL_NUM      = 4,
  parameter int REG_WD           = 32
) (
  input  logic                                  clk_pix,
  input  logic                                  reset_pix,
  input  logic                                  i_clk_en,
  input  logic                                  i_fval,
  input  logic                                  i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                  i_stream_enable,
  input  logic                                  i_acquisition_start,
  input  logic                                  i_encrypt_state,
  output logic                                  o_fval,
  output logic                                  o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                                  o_full_frame_state,
  output logic [REG_WD-1:0]                     ov_frame_pass_cnt,
  output logic [REG_WD-1:0]                     ov_frame_drop_cnt
);

  localparam int DW = SENSOR_DAT_WIDTH * CHANNEL_NUM;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_GAP = 2'd1;
  localparam logic [1:0] PASS     = 2'd2;
  localparam logic [1:0] BLOCK    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       fval_d;
  logic       gate_en;
  logic       fval_rise;
  logic       fval_fall;
  logic       pass_path;

  always_comb begin
    gate_en   = i_stream_enable & i_acquisition_start & i_encrypt_state;
    fval_rise = i_clk_en & i_fval & ~fval_d;
    fval_fall = i_clk_en & ~i_fval & fval_d;
  end

  // WAIT_GAP guarantees we only ever start on a rising edge seen after fval was low,
  // so a frame already in progress is never forwarded partially.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_GAP: if (!i_fval) state_nxt = IDLE;
      IDLE: begin
        if (fval_rise)   state_nxt = gate_en ? PASS : BLOCK;
        else if (i_fval) state_nxt = WAIT_GAP;
      end
      PASS:     if (fval_fall) state_nxt = IDLE;
      BLOCK:    if (fval_fall) state_nxt = IDLE;
      default:  state_nxt = WAIT_GAP;
    endcase
  end

  // The rise cycle itself is forwarded so the output frame is the input delayed by one cycle.
  always_comb begin
    pass_path = (state == PASS) || ((state == IDLE) && fval_rise && gate_en);
  end

  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) begin
      state              <= WAIT_GAP;
      fval_d             <= 1'b0;
      o_fval             <= 1'b0;
      o_lval             <= 1'b0;
      ov_pix_data        <= '0;
      o_full_frame_state <= 1'b0;
      ov_frame_pass_cnt  <= '0;
      ov_frame_drop_cnt  <= '0;
    end else if (i_clk_en) begin
      fval_d             <= i_fval;
      state              <= state_nxt;
      o_full_frame_state <= (state_nxt == PASS);
      if (pass_path) begin
        o_fval      <= i_fval;
        o_lval      <= i_lval & i_fval;
        ov_pix_data <= iv_pix_data;
      end else begin
        o_fval      <= 1'b0;
        o_lval      <= 1'b0;
        ov_pix_data <= {DW{1'b0}};
      end
      if (fval_fall && (state == PASS))
        ov_frame_pass_cnt <= ov_frame_pass_cnt + REG_WD'(1);
      if (fval_fall && (state == BLOCK))
        ov_frame_drop_cnt <= ov_frame_drop_cnt + REG_WD'(1);
    end
  end

endmodule

// File: tb/tb_frame_gate_ctrl.sv
// tb/tb_frame_gate_ctrl.sv - bench for frame_gate_ctrl: vector table, directed frame
// sequences and random traffic against a frame-level reference model.
module tb_frame_gate_ctrl;

  localparam int DW = 40;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          fval = 1'b0;
  logic          lval = 1'b0;
  logic [DW-1:0] data = '0;
  logic          se = 1'b1;
  logic          acq = 1'b1;
  logic          enc = 1'b1;
  logic          o_fval, o_lval, o_ffs;
  logic [DW-1:0] o_data;
  logic [RW-1:0] o_pass, o_drop;

  frame_gate_ctrl #(.SENSOR_DAT_WIDTH(10), .CHANNEL_NUM(4), .REG_WD(RW)) dut (
    .clk_pix(clk), .reset_pix(rst), .i_clk_en(clk_en), .i_fval(fval), .i_lval(lval),
    .iv_pix_data(data), .i_stream_enable(se), .i_acquisition_start(acq),
    .i_encrypt_state(enc), .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(o_data),
    .o_full_frame_state(o_ffs), .ov_frame_pass_cnt(o_pass), .ov_frame_drop_cnt(o_drop)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Frame-level model: a frame's fate is decided at its rising edge and only if fval
  // has been seen low beforehand (armed); fate 0 = none, 1 = passed, 2 = dropped.
  bit            m_prev, m_armed;
  int            m_fate;
  logic          e_fval, e_lval, e_ffs;
  logic [DW-1:0] e_data;
  logic [RW-1:0] e_pass, e_drop;
  bit            tog_mode = 1'b0;
  int            tog_cnt = 10;
  bit            saw_ofval;

  typedef struct {
    logic en, fv, lv, s;
    logic [DW-1:0] d;
    logic efv, elv, effs;
    logic [DW-1:0] ed;
    logic [RW-1:0] ep, edr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_prev = 0; m_armed = 0; m_fate = 0;
    e_fval = 0; e_lval = 0; e_ffs = 0; e_data = '0; e_pass = '0; e_drop = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("reset_state", {13'd0, o_fval, o_lval, o_ffs, o_pass, o_drop, o_data}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic cyc();
    bit rise, fall, gate, pass_now;
    if (clk_en) begin
      gate = se & acq & enc;
      rise = fval & !m_prev;
      fall = !fval & m_prev;
      pass_now = (m_fate == 1) || (m_fate == 0 && m_armed && rise && gate);
      e_fval = pass_now ? fval : 1'b0;
      e_lval = pass_now ? (lval & fval) : 1'b0;
      e_data = pass_now ? data : '0;
      if (m_fate != 0) begin
        if (fall) begin
          if (m_fate == 1) e_pass = e_pass + 1'b1;
          else e_drop = e_drop + 1'b1;
          m_fate = 0;
          m_armed = 1;
        end
      end else if (!fval) m_armed = 1;
      else if (rise && m_armed) m_fate = gate ? 1 : 2;
      else m_armed = 0;
      e_ffs = (m_fate == 1);
      m_prev = fval;
    end
    @(posedge clk); #1;
    chk("cycle", {13'd0, o_fval, o_lval, o_ffs, o_pass, o_drop, o_data},
        {13'd0, e_fval, e_lval, e_ffs, e_pass, e_drop, e_data});
    if (o_fval) saw_ofval = 1;
    if (tog_mode) begin
      tog_cnt--;
      if (tog_cnt <= 0) begin
        se = ~se;
        tog_cnt = $urandom_range(10, 300);
      end
    end
  endtask

  task automatic rand_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    data = t[DW-1:0];
  endtask

  task automatic frames(input int n, input int lines, input int width, input int hblank,
                        input int vblank, input int chg_frame, input logic chg_val);
    for (int f = 0; f < n; f++) begin
      fval = 1'b0; lval = 1'b0;
      for (int v = 0; v < vblank; v++) begin rand_data(); cyc(); end
      fval = 1'b1;
      for (int l = 0; l < lines; l++) begin
        if (f == chg_frame && l == lines / 2) se = chg_val;
        lval = 1'b1;
        for (int w = 0; w < width; w++) begin rand_data(); cyc(); end
        lval = 1'b0;
        for (int h = 0; h < hblank; h++) begin rand_data(); cyc(); end
      end
    end
    fval = 1'b0; lval = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 40'h0,  1'b0, 1'b0, 1'b0, 40'h0,  4'd0, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 40'h11, 1'b1, 1'b0, 1'b1, 40'h11, 4'd0, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 40'h22, 1'b1, 1'b1, 1'b1, 40'h22, 4'd0, 4'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 40'h33, 1'b1, 1'b1, 1'b1, 40'h22, 4'd0, 4'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 40'h44, 1'b1, 1'b1, 1'b1, 40'h44, 4'd0, 4'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 40'h55, 1'b0, 1'b0, 1'b0, 40'h55, 4'd1, 4'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 40'h66, 1'b0, 1'b0, 1'b0, 40'h0,  4'd1, 4'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 40'h77, 1'b0, 1'b0, 1'b0, 40'h0,  4'd1, 4'd0};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 40'h88, 1'b0, 1'b0, 1'b0, 40'h0,  4'd1, 4'd0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 40'h99, 1'b0, 1'b0, 1'b0, 40'h0,  4'd1, 4'd1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      clk_en = tbl[i].en; fval = tbl[i].fv; lval = tbl[i].lv; se = tbl[i].s; data = tbl[i].d;
      cyc();
      chk($sformatf("tbl%0d", i), {13'd0, o_fval, o_lval, o_ffs, o_pass, o_drop, o_data},
          {13'd0, tbl[i].efv, tbl[i].elv, tbl[i].effs, tbl[i].ep, tbl[i].edr, tbl[i].ed});
    end
    clk_en = 1'b1;

    // three full-size frames, all passed
    do_reset(); se = 1; acq = 1; enc = 1;
    frames(3, 64, 64, 4, 8, -1, 1'b0);
    chk("full_pass", {56'd0, o_pass, o_drop}, {56'd0, 4'd3, 4'd0});

    // stream disabled in the middle of frame 2 of 4
    do_reset(); se = 1;
    frames(4, 8, 8, 2, 3, 1, 1'b0);
    chk("se_drop_mid", {56'd0, o_pass, o_drop}, {56'd0, 4'd2, 4'd2});

    // stream enabled in the middle of frame 1 of 2
    do_reset(); se = 0;
    frames(2, 8, 8, 2, 3, 0, 1'b1);
    chk("se_raise_mid", {56'd0, o_pass, o_drop}, {56'd0, 4'd1, 4'd1});

    // single-cycle fval gap between frames
    do_reset(); se = 1;
    frames(2, 4, 4, 1, 1, -1, 1'b0);
    chk("gap1", {56'd0, o_pass, o_drop}, {56'd0, 4'd2, 4'd0});

    // reset mid-frame truncates output, then release with fval high
    do_reset(); se = 1;
    fval = 0; lval = 0; repeat (2) cyc();
    fval = 1; lval = 1; repeat (5) begin rand_data(); cyc(); end
    chk("pre_trunc", {63'd0, o_fval}, 64'd1);
    #2 rst = 1'b1; #1;
    chk("trunc", {61'd0, o_fval, o_lval, o_ffs}, 64'd0);
    do_reset();
    repeat (6) begin rand_data(); lval = ~lval; cyc(); end
    frames(1, 4, 4, 2, 3, -1, 1'b0);
    chk("rst_in_frame", {56'd0, o_pass, o_drop}, {56'd0, 4'd1, 4'd0});

    // encryption check failing with se toggling
    do_reset(); se = 1; enc = 0; saw_ofval = 0; tog_mode = 1; tog_cnt = $urandom_range(10, 300);
    frames(5, 16, 16, 2, 4, -1, 1'b0);
    tog_mode = 0; enc = 1; se = 1;
    chk("enc_no_ofval", {63'd0, saw_ofval}, 64'd0);
    chk("enc_drop5", {56'd0, o_pass, o_drop}, {56'd0, 4'd0, 4'd5});

    // counter wraps modulo 2^REG_WD
    do_reset();
    frames(17, 2, 2, 1, 1, -1, 1'b0);
    chk("wrap", {56'd0, o_pass, o_drop}, {56'd0, 4'd1, 4'd0});

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) fval = ~fval;
      lval = fval & $urandom_range(0, 1);
      clk_en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) begin
        se  = ($urandom_range(0, 3) != 0);
        acq = ($urandom_range(0, 3) != 0);
        enc = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1; #1;
        chk("rand_async_rst", {61'd0, o_fval, o_lval, o_ffs}, 64'd0);
        do_reset();
      end
      rand_data();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
